// File: rtl/serial_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_chain_pkg
//  Description : Shared types and helpers for the serial capture-chain
//                transmitter: FSM state encoding, counter width and parity.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_chain_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Width of a counter able to hold values 0..n
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Even parity over a word of up to 64 bits; narrower words are
    // zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_shift_reg
//  Description : WIDTH-bit load/shift register feeding the serial output.
//                SO always shows the bit currently being transmitted; zeros
//                are shifted in, so the register drains to all-zero once the
//                word has been sent and SO idles low.
//  Ports       : C     - clock, rising edge
//                RN    - synchronous active-low reset
//                LOAD  - load DIN (priority over SHIFT)
//                SHIFT - advance to the next bit
//                DIN   - parallel word
//                SO    - current serial bit
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             C,
    input  logic             RN,
    input  logic             LOAD,
    input  logic             SHIFT,
    input  logic [WIDTH-1:0] DIN,
    output logic             SO
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shifted = {1'b0, sr_q[WIDTH-1:1]};
            assign SO      = sr_q[0];
        end else begin : g_msb_first
            assign shifted = {sr_q[WIDTH-2:0], 1'b0};
            assign SO      = sr_q[WIDTH-1];
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (LOAD) begin
            sr_d = DIN;
        end else if (SHIFT) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge C) begin
        if (!RN) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_chain_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_chain_tx
//  Description : Launch side of a negedge flip-flop capture chain. Accepts a
//                parallel word on a valid/ready handshake and shifts it out
//                one bit per rising edge of C, so a chain clocked on the
//                falling edge sees half a cycle of setup and hold.
//  Ports       : C          - clock, rising edge
//                RN         - synchronous active-low reset
//                DIN        - parallel word, sampled only on accept
//                DIN_VALID  - DIN holds a word
//                DIN_READY  - word can be accepted this cycle (IDLE only)
//                SDO        - serial data to the chain
//                SDO_VALID  - SDO carries a frame bit
//                BUSY       - frame or gap in progress
//                FRAME_DONE - high while the final frame bit is on SDO
//  Config      : SERIAL_CHAIN_PARITY_EN - append an even-parity bit to
//                each frame (frame becomes WIDTH+1 bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_chain_tx
    import serial_chain_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = 2
) (
    input  logic             C,
    input  logic             RN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             SDO,
    output logic             SDO_VALID,
    output logic             BUSY,
    output logic             FRAME_DONE
);

`ifdef SERIAL_CHAIN_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    // Sized for the full frame so the parity build can still hold WIDTH+1
    localparam int CNT_W = cnt_w(FRAME_LEN);
    localparam int GAP_W = (GAP_CYCLES > 0) ? cnt_w(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    // Remaining-bit count while the last data bit is on SDO
    localparam logic [CNT_W-1:0] LAST_DATA_C = CNT_W'(FRAME_LEN - WIDTH + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             frame_end;
    logic             accept;
    logic             sr_so;

    assign accept = (state_q == IDLE) && ready_q && DIN_VALID;

    serial_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_reg (
        .C     (C),
        .RN    (RN),
        .LOAD  (accept),
        .SHIFT (state_q == SHIFT),
        .DIN   (DIN),
        .SO    (sr_so)
    );

`ifdef SERIAL_CHAIN_PARITY_EN
    logic par_q;

    // Parity is captured with the word so later DIN changes cannot affect it
    always_ff @(posedge C) begin
        if (!RN) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= even_parity(64'(DIN));
        end
    end

    assign SDO = (state_q == PAR) ? par_q : sr_so;
`else
    assign SDO = sr_so;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        frame_end = 1'b0;

        // Remaining-bit counter: one per transmitted bit, saturating at zero
        if ((cnt_q != '0) && ((state_q == SHIFT) || (state_q == PAR))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = FRAME_LEN_C;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_DATA_C) begin
`ifdef SERIAL_CHAIN_PARITY_EN
                    state_d = PAR;
`else
                    frame_end = 1'b1;
`endif
                end
            end
            PAR: begin
                frame_end = 1'b1;
            end
            GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_end) begin
            if (GAP_CYCLES == 0) begin
                state_d = IDLE;
            end else begin
                state_d = GAP;
                gap_d   = GAP_W'(GAP_CYCLES);
            end
        end

        // Outputs are registered from the next state so they line up with SDO
        ready_d = (state_d == IDLE);
        valid_d = (state_d == SHIFT) || (state_d == PAR);
        done_d  = valid_d && (cnt_d == CNT_W'(1));
    end

    always_ff @(posedge C) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign DIN_READY  = ready_q;
    assign SDO_VALID  = valid_q;
    assign FRAME_DONE = done_q;
    assign BUSY       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_chain_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_chain_tx
//  Description : Self-checking bench for serial_chain_tx. Three instances:
//                0 = MSB first, 2 gap cycles; 1 = LSB first, 2 gap cycles,
//                driving a model negedge capture chain; 2 = MSB first, no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_chain_tx;

`ifdef SERIAL_CHAIN_PARITY_EN
    localparam int FLEN = 9;
    localparam bit PE   = 1'b1;
`else
    localparam int FLEN = 8;
    localparam bit PE   = 1'b0;
`endif

    logic       clk;
    logic       rn;
    logic [7:0] din       [3];
    logic       din_valid [3];
    logic       rdy       [3];
    logic       sdo       [3];
    logic       vld       [3];
    logic       busy      [3];
    logic       done      [3];
    logic [8:0] chain;

    int n_vec;
    int n_miss;

    typedef struct {
        int         dut;
        logic [7:0] din;
        logic [8:0] exp;   // exp[i] = i-th transmitted bit, exp[8] = parity
        int         gap;
    } vec_t;

    vec_t tbl [8];

    serial_chain_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(2)) u_dut0 (
        .C(clk), .RN(rn), .DIN(din[0]), .DIN_VALID(din_valid[0]),
        .DIN_READY(rdy[0]), .SDO(sdo[0]), .SDO_VALID(vld[0]),
        .BUSY(busy[0]), .FRAME_DONE(done[0])
    );
    serial_chain_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP_CYCLES(2)) u_dut1 (
        .C(clk), .RN(rn), .DIN(din[1]), .DIN_VALID(din_valid[1]),
        .DIN_READY(rdy[1]), .SDO(sdo[1]), .SDO_VALID(vld[1]),
        .BUSY(busy[1]), .FRAME_DONE(done[1])
    );
    serial_chain_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(0)) u_dut2 (
        .C(clk), .RN(rn), .DIN(din[2]), .DIN_VALID(din_valid[2]),
        .DIN_READY(rdy[2]), .SDO(sdo[2]), .SDO_VALID(vld[2]),
        .BUSY(busy[2]), .FRAME_DONE(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream negedge DFF chain; first bit ends at the low end
    always @(negedge clk) chain <= {sdo[1], chain[8:1]};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int d);
        int k;
        k = 0;
        while (rdy[d] !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check("ready_wait", 32'(rdy[d]), 32'd1);
    endtask

    task automatic run_frame(input int d, input logic [7:0] w, input logic [8:0] exp, input int gap);
        int k;
        wait_ready(d);
        din[d]       = w;
        din_valid[d] = 1'b1;
        tick();
        din_valid[d] = 1'b0;
        din[d]       = ~w;            // must not disturb the frame
        for (int i = 0; i < FLEN; i++) begin
            check($sformatf("d%0d_%02h_bit%0d", d, w, i), 32'(sdo[d]), 32'(exp[i]));
            check($sformatf("d%0d_%02h_vld%0d", d, w, i), 32'(vld[d]), 32'd1);
            check($sformatf("d%0d_%02h_done%0d", d, w, i), 32'(done[d]), 32'(i == FLEN - 1));
            check($sformatf("d%0d_%02h_rdy%0d", d, w, i), 32'(rdy[d]), 32'd0);
            check($sformatf("d%0d_%02h_busy%0d", d, w, i), 32'(busy[d]), 32'd1);
            tick();
        end
        check($sformatf("d%0d_%02h_post_vld", d, w), 32'(vld[d]), 32'd0);
        check($sformatf("d%0d_%02h_post_sdo", d, w), 32'(sdo[d]), 32'd0);
        check($sformatf("d%0d_%02h_post_done", d, w), 32'(done[d]), 32'd0);
        if (d == 1) begin
`ifdef SERIAL_CHAIN_PARITY_EN
            check("chain_capture", 32'(chain), 32'(exp));
`else
            check("chain_capture", 32'(chain[8:1]), 32'(w));
`endif
        end
        k = 0;
        while (rdy[d] !== 1'b1 && k < 20) begin
            check($sformatf("d%0d_gap_vld%0d", d, k), 32'(vld[d]), 32'd0);
            check($sformatf("d%0d_gap_done%0d", d, k), 32'(done[d]), 32'd0);
            k++;
            tick();
        end
        check($sformatf("d%0d_gap_len", d), 32'(k), 32'(gap));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rn     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din[i]       = 8'h00;
            din_valid[i] = 1'b0;
        end

        // Hand-computed bit sequences in transmission order
        tbl[0] = '{0, 8'hA5, {1'b0 & PE, 8'hA5}, 2};
        tbl[1] = '{0, 8'h80, {1'b1 & PE, 8'h01}, 2};
        tbl[2] = '{1, 8'h01, {1'b1 & PE, 8'h01}, 2};
        tbl[3] = '{1, 8'hB2, {1'b0 & PE, 8'hB2}, 2};
        tbl[4] = '{2, 8'hFF, {1'b0 & PE, 8'hFF}, 0};
        tbl[5] = '{2, 8'h00, {1'b0 & PE, 8'h00}, 0};
        tbl[6] = '{0, 8'h07, {1'b1 & PE, 8'hE0}, 2};
        tbl[7] = '{0, 8'h03, {1'b0 & PE, 8'hC0}, 2};

        // Reset held for 3 edges with DIN_VALID asserted
        din[0]       = 8'hA5;
        din_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst%0d_rdy", i), 32'(rdy[0]), 32'd0);
            check($sformatf("rst%0d_sdo", i), 32'(sdo[0]), 32'd0);
            check($sformatf("rst%0d_vld", i), 32'(vld[0]), 32'd0);
            check($sformatf("rst%0d_busy", i), 32'(busy[0]), 32'd0);
            check($sformatf("rst%0d_done", i), 32'(done[0]), 32'd0);
        end
        rn = 1'b1;
        tick();
        check("rel_rdy", 32'(rdy[0]), 32'd1);
        check("rel_vld", 32'(vld[0]), 32'd0);
        check("rel_busy", 32'(busy[0]), 32'd0);
        din_valid[0] = 1'b0;
        tick();
        check("idle_vld", 32'(vld[0]), 32'd0);

        for (int v = 0; v < 8; v++) begin
            run_frame(tbl[v].dut, tbl[v].din, tbl[v].exp, tbl[v].gap);
        end

        // Back-to-back words with DIN_VALID held high and no gap
        din[2]       = 8'hFF;
        din_valid[2] = 1'b1;
        wait_ready(2);
        tick();
        din[2] = 8'h00;
        for (int i = 0; i < FLEN; i++) begin
            check($sformatf("b2b_a_bit%0d", i), 32'(sdo[2]), 32'(i < 8));
            check($sformatf("b2b_a_vld%0d", i), 32'(vld[2]), 32'd1);
            tick();
        end
        check("b2b_idle_vld", 32'(vld[2]), 32'd0);
        check("b2b_idle_rdy", 32'(rdy[2]), 32'd1);
        tick();
        for (int i = 0; i < FLEN; i++) begin
            check($sformatf("b2b_b_bit%0d", i), 32'(sdo[2]), 32'd0);
            check($sformatf("b2b_b_vld%0d", i), 32'(vld[2]), 32'd1);
            check($sformatf("b2b_b_done%0d", i), 32'(done[2]), 32'(i == FLEN - 1));
            tick();
        end
        din_valid[2] = 1'b0;
        check("b2b_end_vld", 32'(vld[2]), 32'd0);

        // Abort of 8'h3C during its 4th bit
        wait_ready(0);
        din[0]       = 8'h3C;
        din_valid[0] = 1'b1;
        tick();
        din_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("abort_bit%0d", i), 32'(sdo[0]), 32'(i >= 2));
            if (i < 3) tick();
        end
        rn = 1'b0;
        tick();
        check("abort_sdo", 32'(sdo[0]), 32'd0);
        check("abort_vld", 32'(vld[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        rn = 1'b1;
        tick();
        check("abort_rel_rdy", 32'(rdy[0]), 32'd1);
        check("abort_rel_done", 32'(done[0]), 32'd0);
        run_frame(0, 8'h3C, {1'b0 & PE, 8'h3C}, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
